instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-issue side of the opcode interface: fetches 32-bit LEGv8 words and presents inst_opcode=inst[31:21] to the control unit.
//  Holds the PC, issues in-order requests to instruction memory and buffers returned words in a small FIFO.
//  Accepts branch redirects (CBZ taken / B) from the execute stage and discards wrong-path words.
// PARAMETERS
//  ADDR_W      64  PC / memory address width
//  FIFO_DEPTH  2   instruction buffer entries, power of 2, >=2
//  RESET_PC    0   PC loaded on reset, 4-byte aligned
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       asynchronous reset, active-high
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       memory accepts request
//  imem_req_addr   out  ADDR_W  fetch address (= pc)
//  imem_rsp_valid  in   1       read data valid; responses in request order, >=1 cycle after request
//  imem_rsp_data   in   32      instruction word
//  inst_valid      out  1       instruction available to decode
//  inst_ready      in   1       decode consumes instruction
//  inst            out  32      instruction word (FIFO head)
//  inst_opcode     out  11      inst[31:21], drives control unit opcode
//  inst_pc         out  ADDR_W  address of inst
//  redirect_valid  in   1       branch taken, one-cycle pulse
//  redirect_pc     in   ADDR_W  branch target; bits [1:0] ignored, treated as 00
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=BOOT, FIFO empty, inflight=0, drop=0; imem_req_valid=0, inst_valid=0, inst/inst_opcode/inst_pc=0.
//  FSM BOOT->RUN unconditionally on first clock after rst deasserts (no request in BOOT).
//  RUN: imem_req_valid=1 iff inflight+fifo_count < FIFO_DEPTH; on req fire pc<=pc+4 (wraps modulo 2^ADDR_W), inflight++.
//  Response in RUN with drop==0: push {data,addr} into FIFO, inflight--; credit rule guarantees no overflow; rsp never back-pressured.
//  Entry addr = pc value of matching request (tracked in order alongside FIFO slots).
//  inst_valid = FIFO non-empty; transfer when inst_valid&inst_ready; head pops same edge. Latency req->inst_valid: rsp cycle +1.
//  Redirect (any state): pc<=redirect_pc&~3, FIFO flushed, drop<=inflight (+1 if req fires same cycle, -1 if rsp arrives same cycle, that rsp discarded).
//   Next state FLUSH if resulting drop>0, else RUN. Output transfer in redirect cycle completes normally, then flush.
//  FLUSH: imem_req_valid=0; each rsp discarded, drop--, inflight--; ->RUN when drop reaches 0 (request may issue next cycle).
//  Redirect during FLUSH: adopt new pc, recompute drop as above, stay in FLUSH.
//  Simultaneous push and pop: both occur, count unchanged. Full FIFO: no request issued (credit), never stall rsp.
//  inst_opcode is combinational slice of inst; all other outputs registered or direct FIFO reads.
//  rsp_valid with inflight==0 is a protocol error: ignore, assertion in bench.
// STRUCTURE
//  Shared package legv8_pkg: INST_W=32, OPCODE_W=11, OPCODE_MSB=31/LSB=21, PC_STEP=4, fetch state encoding {BOOT,RUN,FLUSH}.
//  One sub-module: fetch_fifo (sync FIFO, width 32+ADDR_W, depth FIFO_DEPTH, push/pop/flush, count out).
//  Top holds pc, FSM, inflight/drop counters ($clog2(FIFO_DEPTH)+1 bits).
// TESTING
//  Reset: rst high mid-stream -> all outputs 0 immediately, first req addr=0x0 two cycles after release.
//  Straight-line, mem latency 1, inst_ready=1 -> addrs 0,4,8,...; inst_pc matches; LDUR word 0xF8400000 gives inst_opcode=11'h7C2.
//  Back-pressure: inst_ready=0 for 10 cycles -> at most FIFO_DEPTH outstanding+buffered, no lost/duplicated word, order kept.
//  Redirect with 2 in flight to 0x100 -> both rsp dropped, state FLUSH 2 rsp, next req addr=0x100, first inst_pc=0x100.
//  Redirect coinciding with req fire and rsp arrival, redirect_pc=0x203 -> next fetch 0x200, no stale word delivered.
//  pc=2^ADDR_W-4 -> next req addr 0 (wrap); redirect pulse every cycle for 5 cycles -> only last target fetched.

Source files
------------

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 fetch constants and the fetch FSM state encoding
package legv8_pkg;
  localparam int INST_W = 32;
  localparam int OPCODE_W = 11;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch bundle (imem req/rsp, decode inst handshake, redirect); master = fetch unit, slave = memory/decode/execute side
interface instr_fetch_unit_if import legv8_pkg::*; #(parameter int ADDR_W = 64);
  logic imem_req_valid;
  logic imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic inst_valid;
  logic inst_ready;
  logic [INST_W-1:0] inst;
  logic [OPCODE_W-1:0] inst_opcode;
  logic [ADDR_W-1:0] inst_pc;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_opcode, inst_pc,
    input imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input imem_req_valid, imem_req_addr, inst_valid, inst, inst_opcode, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of {inst,pc} entries; ports clk, rst, push, pop, flush, din, dout (head), count
module fetch_fifo #(
  parameter int W = 96,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign dout = mem[rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '{default: '0};
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr] <= din;
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: LEGv8 fetch (pc, in-order imem requests, instruction FIFO, redirect flush); ports clk, rst, bus (instr_fetch_unit_if.master)
module instr_fetch_unit import legv8_pkg::*; #(
  parameter int ADDR_W = 64,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = INST_W + ADDR_W;
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, rsp_addr;
  logic [CW-1:0] inflight, inflight_n, drop, drop_n, count, count_n;
  logic req_valid, req_valid_n, req_fire, rsp, push, pop;
  logic [EW-1:0] head;
  always_comb begin
    req_fire = req_valid & bus.imem_req_ready;
    rsp = bus.imem_rsp_valid & (inflight != '0);
    pop = bus.inst_valid & bus.inst_ready;
    push = rsp & (state == RUN) & (drop == '0) & ~bus.redirect_valid;
    // responses return in order, so the oldest outstanding request lies inflight words behind pc
    rsp_addr = pc - ADDR_W'(inflight) * ADDR_W'(PC_STEP);
    inflight_n = inflight + CW'(req_fire) - CW'(rsp);
    drop_n = bus.redirect_valid ? inflight_n : (state == FLUSH && rsp) ? drop - CW'(1) : drop;
    count_n = bus.redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    state_n = bus.redirect_valid ? ((inflight_n != '0) ? FLUSH : RUN)
            : (state == FLUSH && drop_n != '0) ? FLUSH : RUN;
    pc_n = bus.redirect_valid ? bus.redirect_pc & ~ADDR_W'(3) : req_fire ? pc + ADDR_W'(PC_STEP) : pc;
    req_valid_n = (state_n == RUN) && ((inflight_n + count_n) < CW'(FIFO_DEPTH));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= BOOT;
      pc <= RESET_PC;
      inflight <= '0;
      drop <= '0;
      req_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      inflight <= inflight_n;
      drop <= drop_n;
      req_valid <= req_valid_n;
    end
  fetch_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(bus.redirect_valid),
    .din({bus.imem_rsp_data, rsp_addr}),
    .dout(head),
    .count(count)
  );
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr = pc;
  assign bus.inst_valid = count != '0;
  assign bus.inst = head[EW-1:ADDR_W];
  assign bus.inst_pc = head[ADDR_W-1:0];
  assign bus.inst_opcode = bus.inst[OPCODE_MSB:OPCODE_LSB];
endmodule
